sr_cmd_gen: RTL and testbench
=============================

# sr_cmd_gen

Upstream command stage for the team's SR flip-flop. Takes two raw, asynchronous, bouncing control inputs (set key, reset key), synchronizes and debounces each, and emits single-cycle, mutually exclusive set/reset pulses. Its outputs drive the SR flip-flop's set and reset inputs directly, so the illegal set+reset combination never reaches it.

## Interface
- DEB_CNT, default 4: consecutive stable cycles (after the synchronizer) required to accept a level change; legal range 1 .. 2^CNT_W.
- CNT_W, default 3: debounce counter width.
- clk  input  1  clock; all logic on rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- key_s  input  1  raw set request; asynchronous, may bounce.
- key_r  input  1  raw reset request; asynchronous, may bounce.
- dout_s  output  1  registered set pulse, one cycle wide; feeds SR FF set input.
- dout_r  output  1  registered reset pulse, one cycle wide; feeds SR FF reset input.
- conflict  output  1  registered one-cycle flag: set and reset rising edges collided.

## Operation
- Per channel (s, r) identical pipeline: sync1 -> sync2 (2-FF synchronizer), debounce counter cnt[CNT_W-1:0], debounced level db, delayed level db_d.
- Debounce rule, each edge:
  - sync2 == db: cnt <= 0.
  - sync2 != db and cnt == DEB_CNT-1: db <= sync2, cnt <= 0.
  - sync2 != db otherwise: cnt <= cnt+1.
- Any return of sync2 to db before acceptance clears cnt; the partial count is discarded, not resumed.
- Falling edges are debounced identically but produce no output pulse.
- Rise detect: rise_x = db_x & ~db_d_x; db_d_x <= db_x every edge.
- Output register, each edge:
  - rise_s & ~rise_r: dout_s <= 1, dout_r <= 0, conflict <= 0.
  - rise_r & ~rise_s: dout_r <= 1, dout_s <= 0, conflict <= 0.
  - rise_s & rise_r: dout_r <= 1, dout_s <= 0, conflict <= 1; the set request is dropped, not queued.
  - neither: all three <= 0.
- Invariant: dout_s & dout_r == 0 in every cycle, including immediately after reset.
- A key held high produces exactly one pulse; a new pulse requires the debounced level to fall and rise again.

## Timing
- Reset (n_rst low, async): sync1, sync2, cnt, db, db_d, dout_s, dout_r, conflict all 0 immediately, held while low.
- Latency, key constant high from edge 0 (first edge sampling it high):
  - sync1 = 1 after edge 0; sync2 = 1 after edge 1.
  - db = 1 after edge DEB_CNT+1.
  - dout_x = 1 after edge DEB_CNT+2, for exactly one cycle. With DEB_CNT=4 this is edge 6.
- Minimum accepted pulse: a high level at sync2 lasting fewer than DEB_CNT cycles is filtered completely.
- Key held high through reset release: treated as a new rise; a pulse appears DEB_CNT+2 edges after the first post-reset edge.
- Reset asserted mid-debounce or mid-pulse: state is cleared, and no pulse is emitted after release unless the key is still high. If it is, the full latency restarts.
- Channels are independent until the output register. Collision is judged only on same-edge rise_s/rise_r. Rises one cycle apart give two separate pulses with conflict = 0.
- DEB_CNT = 1: db follows sync2 after one mismatching edge. Total latency is 3 edges.

## Test plan
- Clean set, DEB_CNT=4: key_s 0->1 held, key_r=0 -> dout_s high exactly one cycle after edge 6; dout_r=0 and conflict=0 throughout; no further pulse while key_s is held.
- Bounce: key_s toggles 1,0,1,1,0 (one cycle each), then stays 1 -> no pulse during the bounce; exactly one dout_s pulse, 6 edges after the final rise is sampled.
- Glitch: key_r high for 3 cycles, then 0 -> dout_r stays 0; cnt returns to 0.
- Collision: key_s and key_r rise on the same edge -> after edge 6, dout_r=1 and conflict=1 for one cycle; dout_s stays 0.
- Staggered: key_r rises one cycle after key_s -> dout_s pulse after edge 6, dout_r pulse after edge 7; conflict=0; outputs never both 1.
- Reset mid-operation: n_rst pulsed low at edge 4 of a key_s rise, then released with key_s still high -> all outputs 0 during reset; one dout_s pulse DEB_CNT+2 edges after release.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command front end for the SR flip-flop.
// Two raw, asynchronous, bouncing keys (set, reset) are each synchronized
// through two flops and debounced. Each accepted rising level becomes a
// single-cycle pulse. The output register never asserts set and reset
// together. When both rise on the same edge, reset wins and conflict is
// flagged for that cycle.
// Channel index 0 is the set key and channel index 1 is the reset key.
module sr_cmd_gen #(
    parameter int DEB_CNT = 4,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic key_s,
    input  logic key_r,
    output logic dout_s,
    output logic dout_r,
    output logic conflict
);

    // Count value on the last mismatching edge before a new level is accepted.
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CNT - 1);

    logic [1:0]            key_raw;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;
    logic [1:0]            db_q;
    logic [1:0]            db_d;
    logic [1:0]            dly_q;
    logic [1:0]            rise;

    logic dout_s_q, dout_s_d;
    logic dout_r_q, dout_r_d;
    logic conflict_q, conflict_d;

    assign key_raw = {key_r, key_s};

    // Two-flop synchronizer for both raw keys.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce decision. Any match with the accepted level discards a
    // partial count, so a bounce restarts the qualification from zero.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] == db_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_TC) begin
                db_d[ch]  = sync2_q[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // Debounce counters, accepted levels and one-cycle delayed copies.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
            db_q  <= '0;
            dly_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
            dly_q <= db_q;
        end
    end

    assign rise = db_q & ~dly_q;

    // Output arbitration. On a collision reset has priority and the set
    // request is dropped, so set and reset are never asserted together.
    always_comb begin
        dout_s_d   = rise[0] & ~rise[1];
        dout_r_d   = rise[1];
        conflict_d = rise[0] & rise[1];
    end

    // Registered single-cycle pulses; all clear in reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dout_s_q   <= 1'b0;
            dout_r_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            dout_s_q   <= dout_s_d;
            dout_r_q   <= dout_r_d;
            conflict_q <= conflict_d;
        end
    end

    assign dout_s   = dout_s_q;
    assign dout_r   = dout_r_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: directed latency/filter cases with literal edge
// expectations, then randomized bouncing keys and occasional resets, all
// compared every cycle against a behavioural reference.
module tb_sr_cmd_gen;

    localparam int D = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    logic key_s = 1'b0;
    logic key_r = 1'b0;
    logic dout_s, dout_r, conflict;

    int total = 0;
    int bad   = 0;

    sr_cmd_gen #(.DEB_CNT(D), .CNT_W(3)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .key_s    (key_s),
        .key_r    (key_r),
        .dout_s   (dout_s),
        .dout_r   (dout_r),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    // Reference: a key reaches the debouncer two edges after it is sampled.
    // A new level is accepted once the last D delayed samples all disagree
    // with the current accepted level. The outputs follow from the 0->1
    // changes of the accepted level, one edge later.
    logic [1:0]   ksh [2];
    logic [D-1:0] win [2];
    logic         m_db [2];
    logic         m_dly [2];
    logic         rise_m [2];
    logic         nxt_m [2];
    logic         k_m, s2_m;
    logic         e_s = 1'b0, e_r = 1'b0, e_c = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                ksh[ch]   = '0;
                win[ch]   = '0;
                m_db[ch]  = 1'b0;
                m_dly[ch] = 1'b0;
            end
            e_s = 1'b0;
            e_r = 1'b0;
            e_c = 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                k_m     = (ch == 0) ? key_s : key_r;
                s2_m    = ksh[ch][1];
                ksh[ch] = {ksh[ch][0], k_m};
                win[ch] = {win[ch][D-2:0], s2_m};
                nxt_m[ch] = m_db[ch];
                if (m_db[ch] ? (win[ch] == '0) : (win[ch] == '1))
                    nxt_m[ch] = ~m_db[ch];
                rise_m[ch] = m_db[ch] & ~m_dly[ch];
            end
            e_s = rise_m[0] & ~rise_m[1];
            e_r = rise_m[1];
            e_c = rise_m[0] & rise_m[1];
            for (int ch = 0; ch < 2; ch++) begin
                m_dly[ch] = m_db[ch];
                m_db[ch]  = nxt_m[ch];
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        check("model_dout_s", dout_s, e_s);
        check("model_dout_r", dout_r, e_r);
        check("model_conflict", conflict, e_c);
        check("exclusive", dout_s & dout_r, 1'b0);
    end

    // Bit e of ps/pr is the key level sampled at edge e. es/er/ec give the
    // single edge after which each output must be high (-1: never).
    task automatic run_pat(input string name, input logic [23:0] ps, input logic [23:0] pr,
                           input int es, input int er, input int ec);
        for (int e = 0; e < 24; e++) begin
            @(negedge clk);
            key_s = ps[e];
            key_r = pr[e];
            @(posedge clk);
            #1;
            check({name, "_s"}, dout_s, e == es);
            check({name, "_r"}, dout_r, e == er);
            check({name, "_c"}, conflict, e == ec);
        end
        @(negedge clk);
        key_s = 1'b0;
        key_r = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #2 n_rst = 1'b0;
        #1;
        check("rst_dout_s", dout_s, 1'b0);
        check("rst_dout_r", dout_r, 1'b0);
        check("rst_conflict", conflict, 1'b0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);

        run_pat("clean_set", 24'hFFFFFF, 24'h000000, 6, -1, -1);
        run_pat("bounce",    24'hFFFFED, 24'h000000, 11, -1, -1);
        run_pat("glitch",    24'h000000, 24'h000007, -1, -1, -1);
        run_pat("collision", 24'hFFFFFF, 24'hFFFFFF, -1, 6, 6);
        run_pat("stagger",   24'hFFFFFF, 24'hFFFFFE, 6, 7, -1);

        // Reset in the middle of a set debounce, key still held afterwards.
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            key_s = 1'b1;
            @(posedge clk);
            #1;
            check("pre_rst_s", dout_s, 1'b0);
        end
        n_rst = 1'b0;
        #1;
        check("in_rst_s", dout_s, 1'b0);
        check("in_rst_r", dout_r, 1'b0);
        check("in_rst_c", conflict, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_s", dout_s, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk);
            #1;
            check("post_rst_s", dout_s, e == 6);
            check("post_rst_r", dout_r, 1'b0);
        end
        @(negedge clk);
        key_s = 1'b0;
        repeat (12) @(negedge clk);

        // Randomized bouncing keys with occasional collisions and resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) key_s = ~key_s;
            if ($urandom_range(0, 7) == 0) key_r = ~key_r;
            if ($urandom_range(0, 39) == 0) begin
                key_s = 1'b1;
                key_r = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) begin
                key_s = 1'b0;
                key_r = 1'b0;
            end
            n_rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
